// File: rtl/pool_pkg.sv
// Shared definitions for the pooling pipeline: default pixel geometry,
// the pixel word type, bridge FSM states and config legality check.
package pool_pkg;

  localparam int DEF_CHANNEL_SIZE = 64;
  localparam int DEF_DATA_W       = 32;

  typedef logic [DEF_CHANNEL_SIZE-1:0][DEF_DATA_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } bridge_state_e;

  // Both dimensions must be even so every pixel belongs to exactly one 2x2 window.
  function automatic logic cfg_legal(input int unsigned width,
                                     input int unsigned height,
                                     input int unsigned max_width);
    return (width[0] == 1'b0) && (width >= 2) && (width <= max_width) &&
           (height[0] == 1'b0) && (height >= 2);
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Single-row pixel store: one synchronous write port, two combinational read ports.
module pool_line_buf #(
  parameter int WIDTH = 2048,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/pool_rd_bridge.sv
// Converts a raster pixel stream into 2x2 pooling windows: even rows are
// buffered, odd rows pair up with the buffered row to form each window.
module pool_rd_bridge import pool_pkg::*; #(
  parameter int CHANNEL_SIZE = DEF_CHANNEL_SIZE,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_WIDTH    = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2(MAX_WIDTH):0]     cfg_width,
  input  logic [15:0]                    cfg_height,
  input  logic [CHANNEL_SIZE*DATA_W-1:0] pix_in,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  output logic [CHANNEL_SIZE*DATA_W-1:0] in1,
  output logic [CHANNEL_SIZE*DATA_W-1:0] in2,
  output logic [CHANNEL_SIZE*DATA_W-1:0] in3,
  output logic [CHANNEL_SIZE*DATA_W-1:0] in4,
  output logic                           in_en,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err
);

  localparam int PW = CHANNEL_SIZE * DATA_W;
  localparam int AW = $clog2(MAX_WIDTH);
  localparam int CW = AW + 1;

  bridge_state_e state_q, state_d;
  logic [CW-1:0] width_q, width_d, col_q, col_d;
  logic [15:0]   height_q, height_d, row_q, row_d;
  logic [PW-1:0] held_q, held_d;
  logic [PW-1:0] in1_q, in1_d, in2_q, in2_d, in3_q, in3_d, in4_q, in4_d;
  logic          in_en_q, in_en_d, done_q, done_d, cfg_err_q, cfg_err_d;

  logic          xfer, last_col, last_row, lb_we;
  logic [PW-1:0] lb_rd_a, lb_rd_b;

  assign xfer     = pix_valid && (state_q == ST_RUN);
  assign last_col = (col_q == width_q - CW'(1));
  assign last_row = (row_q == height_q - 16'd1);
  assign lb_we    = xfer && !row_q[0];

  pool_line_buf #(.WIDTH(PW), .DEPTH(MAX_WIDTH), .AW(AW)) u_line_buf (
    .clk     (clk),
    .we      (lb_we),
    .waddr   (col_q[AW-1:0]),
    .wdata   (pix_in),
    .raddr_a (col_q[AW-1:0] - AW'(1)),
    .raddr_b (col_q[AW-1:0]),
    .rdata_a (lb_rd_a),
    .rdata_b (lb_rd_b)
  );

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    col_d     = col_q;
    row_d     = row_q;
    held_d    = held_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    in3_d     = in3_q;
    in4_d     = in4_q;
    in_en_d   = 1'b0;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_legal(32'(cfg_width), 32'(cfg_height), 32'(MAX_WIDTH))) begin
            state_d  = ST_RUN;
            width_d  = cfg_width;
            height_d = cfg_height;
            col_d    = '0;
            row_d    = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          // Odd rows complete windows: left pixel is parked, right pixel fires.
          if (row_q[0]) begin
            if (!col_q[0]) begin
              held_d = pix_in;
            end else begin
              in1_d   = lb_rd_a;
              in2_d   = lb_rd_b;
              in3_d   = held_q;
              in4_d   = pix_in;
              in_en_d = 1'b1;
            end
          end
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = ST_FLUSH;
            end else begin
              row_d = row_q + 16'd1;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      width_q   <= '0;
      height_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      held_q    <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      in3_q     <= '0;
      in4_q     <= '0;
      in_en_q   <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      height_q  <= height_d;
      col_q     <= col_d;
      row_q     <= row_d;
      held_q    <= held_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      in3_q     <= in3_d;
      in4_q     <= in4_d;
      in_en_q   <= in_en_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign pix_ready = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign in1       = in1_q;
  assign in2       = in2_q;
  assign in3       = in3_q;
  assign in4       = in4_q;
  assign in_en     = in_en_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: doc/pool_rd_bridge.md
POOL_RD_BRIDGE -- requirements
Module: pool_rd_bridge

Interface
REQ-001 SHALL have parameter CHANNEL_SIZE, default 64, channels per pixel word.
REQ-002 SHALL have parameter DATA_W, default 32, bits per channel element.
REQ-003 SHALL have parameter MAX_WIDTH, default 64, max pixels per feature-map row.
REQ-004 SHALL have port clk, input, 1, the single clock (one clock; all logic on rising edge).
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1, one-cycle pulse launching a frame.
REQ-007 SHALL have port cfg_width, input, $clog2(MAX_WIDTH)+1, pixels per row, sampled at start.
REQ-008 SHALL have port cfg_height, input, 16, rows per frame, sampled at start.
REQ-009 SHALL have port pix_in, input, CHANNEL_SIZE x DATA_W, raster-order pixel.
REQ-010 SHALL have port pix_valid, input, 1, pix_in valid.
REQ-011 SHALL have port pix_ready, output, 1, bridge accepts pix_in this cycle.
REQ-012 SHALL have ports in1, in2, in3, in4, output, CHANNEL_SIZE x DATA_W each, 2x2 window: top-left, top-right, bottom-left, bottom-right.
REQ-013 SHALL have port in_en, output, 1, window valid, one cycle per window, for the downstream pooling stage.
REQ-014 SHALL have ports busy, done, cfg_err, output, 1 each: frame active; one-cycle end pulse; one-cycle bad-config pulse.

Function
REQ-015 SHALL implement FSM IDLE -> RUN on start with legal config; RUN -> FLUSH after last pixel accepted; FLUSH -> IDLE after final window issued, pulsing done.
REQ-016 SHALL treat config legal only if cfg_width even, 2 <= cfg_width <= MAX_WIDTH, cfg_height even and >= 2; otherwise pulse cfg_err for one cycle and stay IDLE.
REQ-017 SHALL ignore start while not IDLE.
REQ-018 SHALL assert pix_ready only in RUN; transfer occurs when pix_valid && pix_ready.
REQ-019 SHALL keep column counter col (0..cfg_width-1) and row counter row (0..cfg_height-1), advancing only on transfer; col wraps to 0 and row increments at cfg_width-1.
REQ-020 SHALL write pixels of even rows into line buffer at address col.
REQ-021 SHALL hold odd-row, even-col pixels in a side register.
REQ-022 SHALL, on transfer at odd row, odd col, register in1=linebuf[col-1], in2=linebuf[col], in3=held pixel, in4=pix_in, and assert in_en exactly the next cycle (latency 1).
REQ-023 SHALL drive in_en low in all other cycles; in1..in4 hold last window when in_en low.
REQ-024 SHALL emit exactly (cfg_width/2)*(cfg_height/2) windows per frame, in row-major window order.
REQ-025 SHALL tolerate arbitrary pix_valid gaps; windows depend only on transferred pixels.
REQ-026 SHALL not apply backpressure from downstream (downstream always accepts).
REQ-027 SHALL keep busy high in RUN and FLUSH, low in IDLE.

Reset
REQ-028 SHALL, while rst high, force state IDLE, counters 0, held pixel 0, in1..in4 0, in_en 0, pix_ready 0, busy 0, done 0, cfg_err 0.
REQ-029 SHALL abort any frame on rst mid-operation without emitting further windows or done; line buffer contents need not be cleared.

Structure
REQ-030 SHALL take CHANNEL_SIZE, DATA_W defaults and a pixel typedef (CHANNEL_SIZE x DATA_W packed) from shared package pool_pkg, which pooling stages also import.
REQ-031 SHALL place the row storage in sub-module pool_line_buf (MAX_WIDTH-deep, one write port, two combinational read ports).

Verification
REQ-032 SHALL cover 4x4 frame, ch k of pixel (r,c) = 100r+10c+k, no gaps -> 4 windows; window 0 in1/in2/in3/in4 ch0 = 0/10/100/110; done 1 cycle after last in_en.
REQ-033 SHALL cover same frame with pix_valid random 50% -> identical windows and order.
REQ-034 SHALL cover cfg_width=3 start -> cfg_err pulse, busy stays 0, pix_ready 0.
REQ-035 SHALL cover rst asserted after 6 transfers of a 4x4 frame -> next cycle all outputs 0, no done; new 2x2 frame then yields 1 correct window.
REQ-036 SHALL cover start pulsed during RUN -> ignored, frame count unchanged.
REQ-037 SHALL cover MAX_WIDTH=64 x 2 rows -> 32 windows, last in1 = pixel (0,62).
